uart_capture_sequencer: RTL

Sequences the UART byte decoder for logic-analyzer capture. Drives the decoder's detect_only configuration and watches its valid/detected strobes. Arms on command, waits for a masked trigger byte, and captures a burst of decoded bytes into a small internal buffer. Hands the captured bytes to the readout path over a valid/ready handshake.

---
 rtl/uart_capture_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_capture_sequencer.sv
// Capture sequencer for the UART byte decoder: arms on command, waits for a
// masked trigger byte, buffers a burst of decoded bytes and hands them out over valid/ready.
module uart_capture_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int AW      = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          arm_i,
  input  logic          abort_i,
  input  logic          trig_en_i,
  input  logic [7:0]    trig_byte_i,
  input  logic [7:0]    trig_mask_i,
  input  logic [7:0]    dec_data_i,
  input  logic          dec_valid_i,
  input  logic          dec_detected_i,
  output logic          dec_detect_only_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [7:0]    rd_data_o,
  output logic [1:0]    state_o,
  output logic [AW:0]   count_o,
  output logic [7:0]    act_count_o,
  output logic          timed_out_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam int             TW        = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]  IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]    DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    ONE_C     = (AW + 1)'(1);

  state_e          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [7:0]      act_q, act_d;
  logic            timed_out_q, timed_out_d;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            trig_hit;
  logic            rd_valid_c;

  assign trig_hit   = !trig_en_i || (((dec_data_i ^ trig_byte_i) & trig_mask_i) == 8'h00);
  assign rd_valid_c = (state_q == S_DONE) && (rd_ptr_q < count_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      idle_cnt_q  <= '0;
      act_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      idle_cnt_q  <= idle_cnt_d;
      act_q       <= act_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= dec_data_i;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    idle_cnt_d  = idle_cnt_q;
    act_d       = act_q;
    timed_out_d = timed_out_q;
    wr_en       = 1'b0;
    wr_addr     = count_q[AW-1:0];

    if (abort_i) begin
      state_d  = S_IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (dec_detected_i && (act_q != 8'hFF)) act_d = act_q + 8'd1;
          if (arm_i) begin
            state_d     = S_ARMED;
            count_d     = '0;
            rd_ptr_d    = '0;
            idle_cnt_d  = '0;
            timed_out_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (dec_valid_i && trig_hit) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            count_d    = ONE_C;
            idle_cnt_d = '0;
            state_d    = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // A byte on the expiry cycle wins over the timeout.
          if (dec_valid_i) begin
            if (count_q < DEPTH_C) begin
              wr_en      = 1'b1;
              count_d    = count_q + ONE_C;
              idle_cnt_d = '0;
              if (count_q + ONE_C == DEPTH_C) state_d = S_DONE;
            end
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_d     = S_DONE;
            timed_out_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
          end
        end
        S_DONE: begin
          if (rd_valid_c && rd_ready_i) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
            if (rd_ptr_q + ONE_C == count_q) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dec_detect_only_o = (state_q == S_IDLE) || (state_q == S_DONE);
  assign rd_valid_o        = rd_valid_c;
  assign rd_data_o         = rd_valid_c ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign state_o           = state_q;
  assign count_o           = count_q;
  assign act_count_o       = act_q;
  assign timed_out_o       = timed_out_q;

endmodule
